// File: rtl/interrupt_request_controller_if.sv
// Handshake/bus bundle between peripheral requests, the interrupt controller and the CPU core.
// The master modport is the controller's view; slave is the surrounding system's view.
interface interrupt_request_controller_if #(
  parameter int unsigned N_SRC = 8
) ();

  logic [N_SRC-1:0] irq_req;
  logic [N_SRC-1:0] irq_mask;
  logic             nmi_req;
  logic             INA;
  logic             INT;
  logic             NMI;
  logic             INTD;
  logic [N_SRC-1:0] irq_ack;
  logic             busy;

  modport master (
    input  irq_req,
    input  irq_mask,
    input  nmi_req,
    input  INA,
    output INT,
    output NMI,
    output INTD,
    output irq_ack,
    output busy
  );

  modport slave (
    output irq_req,
    output irq_mask,
    output nmi_req,
    output INA,
    input  INT,
    input  NMI,
    input  INTD,
    input  irq_ack,
    input  busy
  );

endinterface

// File: rtl/interrupt_request_controller.sv
// Device-side interrupt controller: arbitrates maskable requests and an edge-triggered NMI,
// raises INT/NMI to the CPU, waits for INA and, for maskable interrupts, shifts the winning
// vector out MSB first on INTD and pulses the serviced device's ack.
module interrupt_request_controller #(
  parameter int unsigned N_SRC   = 8,
  parameter int unsigned VEC_W   = 3,
  parameter int unsigned TIMEOUT = 64
) (
  input logic                           clk,
  input logic                           rst,
  interrupt_request_controller_if.master bus
);

  localparam int unsigned CntW = $clog2(VEC_W + 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] BitLast = CntW'(VEC_W - 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StNmiReq,
    StIntReq,
    StVecShift,
    StGap
  } state_e;

  state_e state_q, state_d;

  logic             nmi_prev_q;
  logic             nmi_pending_q, nmi_pending_d;
  logic [TmoW-1:0]  tmo_cnt_q;
  logic [VEC_W-1:0] vec_q;
  logic [VEC_W-1:0] shift_q;
  logic [CntW-1:0]  bit_cnt_q;

  logic [N_SRC-1:0] pend;
  logic [VEC_W-1:0] winner;
  logic             nmi_edge;
  logic             tmo_last;
  logic             shift_last;

  assign pend       = bus.irq_req & ~bus.irq_mask;
  assign nmi_edge   = bus.nmi_req & ~nmi_prev_q;
  assign tmo_last   = (tmo_cnt_q == TmoLast);
  assign shift_last = (bit_cnt_q == BitLast);

  // Lowest-index pending source wins; scan from the top so the lowest hit is assigned last.
  always_comb begin
    winner = '0;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (pend[i]) winner = VEC_W'(i);
    end
  end

  // NMI edges set the pending flag in any state; acknowledge in StNmiReq clears it.
  always_comb begin
    nmi_pending_d = nmi_pending_q;
    if (state_q == StNmiReq && bus.INA) nmi_pending_d = 1'b0;
    if (nmi_edge) nmi_pending_d = 1'b1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; arbitration only happens in StIdle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (nmi_pending_q) begin
          state_d = StNmiReq;
        end else if (|pend) begin
          state_d = StIntReq;
        end
      end
      StNmiReq: begin
        if (bus.INA) state_d = StGap;
      end
      StIntReq: begin
        if (bus.INA) begin
          state_d = StVecShift;
        end else if (tmo_last) begin
          state_d = StGap;
        end
      end
      StVecShift: begin
        if (shift_last) state_d = StGap;
      end
      StGap: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Datapath: NMI edge detect, timeout counter, vector latch and serialiser.
  always_ff @(posedge clk) begin
    if (rst) begin
      nmi_prev_q    <= 1'b1;
      nmi_pending_q <= 1'b0;
      tmo_cnt_q     <= '0;
      vec_q         <= '0;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
    end else begin
      nmi_prev_q    <= bus.nmi_req;
      nmi_pending_q <= nmi_pending_d;

      // Counter is zero whenever INT_REQ is entered and counts each cycle spent there.
      if (state_q == StIntReq) begin
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end else begin
        tmo_cnt_q <= '0;
      end

      // Vector stays latched for the whole service even if the request or mask changes.
      if (state_q == StIdle && !nmi_pending_q && |pend) begin
        vec_q <= winner;
      end

      if (state_q == StIntReq && bus.INA) begin
        shift_q   <= vec_q;
        bit_cnt_q <= '0;
      end else if (state_q == StVecShift) begin
        shift_q   <= shift_q << 1;
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end
    end
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    bus.INT     = 1'b0;
    bus.NMI     = 1'b0;
    bus.INTD    = 1'b0;
    bus.irq_ack = '0;
    bus.busy    = (state_q != StIdle);
    unique case (state_q)
      StIdle: begin
      end
      StNmiReq: begin
        bus.NMI = 1'b1;
      end
      StIntReq: begin
        bus.INT = 1'b1;
      end
      StVecShift: begin
        bus.INTD = shift_q[VEC_W-1];
        if (shift_last) bus.irq_ack = {{(N_SRC - 1){1'b0}}, 1'b1} << vec_q;
      end
      StGap: begin
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_interrupt_request_controller.sv
// Directed testbench for interrupt_request_controller with hand-computed expectations.
module tb_interrupt_request_controller;

  logic clk;
  logic rst;
  int   passed;
  int   total;

  interrupt_request_controller_if #(.N_SRC(8)) bus ();

  interrupt_request_controller #(
    .N_SRC  (8),
    .VEC_W  (3),
    .TIMEOUT(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; outputs are observed 1 time unit after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst          = 1'b1;
    bus.irq_req  = '0;
    bus.irq_mask = '0;
    bus.nmi_req  = 1'b0;
    bus.INA      = 1'b0;
    tick();
    tick();
    total++; if ({bus.INT, bus.NMI, bus.INTD, bus.busy} !== 4'b0000)
      $display("FAIL reset_outs got=%b want=0000", {bus.INT, bus.NMI, bus.INTD, bus.busy});
    else passed++;
    total++; if (bus.irq_ack !== 8'h00) $display("FAIL reset_ack got=%h want=00", bus.irq_ack);
    else passed++;
    rst = 1'b0;
    tick();
    total++; if (bus.busy !== 1'b0) $display("FAIL reset_idle got=%b want=0", bus.busy);
    else passed++;
  endtask

  task automatic test_basic;
    bus.irq_req = 8'h20;
    tick();
    total++; if (bus.INT !== 1'b1) $display("FAIL t1_int got=%b want=1", bus.INT);
    else passed++;
    bus.INA = 1'b1;
    tick();
    bus.INA = 1'b0;
    total++; if ({bus.INT, bus.INTD, bus.irq_ack} !== {1'b0, 1'b1, 8'h00})
      $display("FAIL t1_bit0 got=%b%b%h want=0100", bus.INT, bus.INTD, bus.irq_ack);
    else passed++;
    tick();
    total++; if ({bus.INT, bus.INTD, bus.irq_ack} !== {1'b0, 1'b0, 8'h00})
      $display("FAIL t1_bit1 got=%b%b%h want=0000", bus.INT, bus.INTD, bus.irq_ack);
    else passed++;
    tick();
    total++; if ({bus.INT, bus.INTD, bus.irq_ack} !== {1'b0, 1'b1, 8'h20})
      $display("FAIL t1_bit2 got=%b%b%h want=0120", bus.INT, bus.INTD, bus.irq_ack);
    else passed++;
    bus.irq_req = '0;
    tick();
    total++; if ({bus.INT, bus.NMI, bus.INTD, bus.busy, bus.irq_ack} !== {4'b0001, 8'h00})
      $display("FAIL t1_gap got=%b%b%b%b%h want=0001_00", bus.INT, bus.NMI, bus.INTD, bus.busy,
               bus.irq_ack);
    else passed++;
    tick();
    total++; if (bus.busy !== 1'b0) $display("FAIL t1_idle got=%b want=0", bus.busy);
    else passed++;
  endtask

  task automatic test_mask;
    logic [2:0] bits;
    bus.irq_req  = 8'h28;
    bus.irq_mask = 8'h08;
    tick();
    bus.INA = 1'b1;
    tick();
    bus.INA = 1'b0;
    bits[2] = bus.INTD;
    tick();
    bits[1] = bus.INTD;
    tick();
    bits[0] = bus.INTD;
    total++; if (bits !== 3'd5) $display("FAIL t2_vec5 got=%0d want=5", bits);
    else passed++;
    total++; if (bus.irq_ack !== 8'h20) $display("FAIL t2_ack5 got=%h want=20", bus.irq_ack);
    else passed++;
    bus.irq_req  = 8'h08;
    bus.irq_mask = 8'h00;
    tick();
    total++; if ({bus.INT, bus.busy} !== 2'b01)
      $display("FAIL t2_gap got=%b%b want=01", bus.INT, bus.busy);
    else passed++;
    tick();
    total++; if ({bus.INT, bus.busy} !== 2'b00)
      $display("FAIL t2_idle got=%b%b want=00", bus.INT, bus.busy);
    else passed++;
    tick();
    total++; if (bus.INT !== 1'b1) $display("FAIL t2_int3 got=%b want=1", bus.INT);
    else passed++;
    bus.INA = 1'b1;
    tick();
    bus.INA = 1'b0;
    bits[2] = bus.INTD;
    tick();
    bits[1] = bus.INTD;
    tick();
    bits[0] = bus.INTD;
    total++; if ({bits, bus.irq_ack} !== {3'd3, 8'h08})
      $display("FAIL t2_vec3 got=%0d/%h want=3/08", bits, bus.irq_ack);
    else passed++;
    bus.irq_req = '0;
    tick();
    tick();
  endtask

  task automatic test_nmi_priority;
    logic [2:0] bits;
    bus.irq_req  = 8'h01;
    bus.irq_mask = 8'h01;
    bus.nmi_req  = 1'b1;
    tick();
    bus.irq_mask = 8'h00;
    tick();
    total++; if ({bus.NMI, bus.INT, bus.INTD} !== 3'b100)
      $display("FAIL t3_nmi got=%b%b%b want=100", bus.NMI, bus.INT, bus.INTD);
    else passed++;
    tick();
    tick();
    total++; if ({bus.NMI, bus.INT} !== 2'b10)
      $display("FAIL t3_nmi_hold got=%b%b want=10", bus.NMI, bus.INT);
    else passed++;
    bus.INA = 1'b1;
    tick();
    bus.INA = 1'b0;
    total++; if ({bus.NMI, bus.INT, bus.INTD, bus.busy} !== 4'b0001)
      $display("FAIL t3_nmi_gap got=%b%b%b%b want=0001", bus.NMI, bus.INT, bus.INTD, bus.busy);
    else passed++;
    tick();
    total++; if ({bus.NMI, bus.INT, bus.INTD} !== 3'b000)
      $display("FAIL t3_idle got=%b%b%b want=000", bus.NMI, bus.INT, bus.INTD);
    else passed++;
    tick();
    total++; if ({bus.INT, bus.NMI} !== 2'b10)
      $display("FAIL t3_int0 got=%b%b want=10", bus.INT, bus.NMI);
    else passed++;
    bus.INA = 1'b1;
    tick();
    bus.INA = 1'b0;
    bits[2] = bus.INTD;
    tick();
    bits[1] = bus.INTD;
    tick();
    bits[0] = bus.INTD;
    total++; if ({bits, bus.irq_ack} !== {3'd0, 8'h01})
      $display("FAIL t3_vec0 got=%0d/%h want=0/01", bits, bus.irq_ack);
    else passed++;
    bus.irq_req = '0;
    bus.nmi_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_timeout;
    int   high_cycles;
    logic ack_seen;
    bus.irq_req = 8'h01;
    tick();
    high_cycles = 0;
    ack_seen    = 1'b0;
    while (bus.INT === 1'b1 && high_cycles < 200) begin
      high_cycles++;
      if (bus.irq_ack !== 8'h00) ack_seen = 1'b1;
      tick();
    end
    total++; if (high_cycles != 64) $display("FAIL t4_hold got=%0d want=64", high_cycles);
    else passed++;
    total++; if ({ack_seen, bus.irq_ack, bus.busy} !== {1'b0, 8'h00, 1'b1})
      $display("FAIL t4_noack got=%b/%h/%b want=0/00/1", ack_seen, bus.irq_ack, bus.busy);
    else passed++;
    tick();
    total++; if (bus.INT !== 1'b0) $display("FAIL t4_low got=%b want=0", bus.INT);
    else passed++;
    tick();
    total++; if (bus.INT !== 1'b1) $display("FAIL t4_reassert got=%b want=1", bus.INT);
    else passed++;
    // INA on the 64th INT cycle must still win over the timeout.
    repeat (63) tick();
    total++; if (bus.INT !== 1'b1) $display("FAIL t4_last got=%b want=1", bus.INT);
    else passed++;
    bus.INA = 1'b1;
    tick();
    bus.INA = 1'b0;
    tick();
    tick();
    total++; if (bus.irq_ack !== 8'h01) $display("FAIL t4_late_ina got=%h want=01", bus.irq_ack);
    else passed++;
    bus.irq_req = '0;
    tick();
    tick();
  endtask

  task automatic test_nmi_during_shift;
    bus.irq_req = 8'h04;
    tick();
    bus.INA = 1'b1;
    tick();
    bus.INA     = 1'b0;
    bus.nmi_req = 1'b1;
    tick();
    total++; if ({bus.INTD, bus.NMI} !== 2'b10)
      $display("FAIL t5_bit1 got=%b%b want=10", bus.INTD, bus.NMI);
    else passed++;
    tick();
    total++; if ({bus.INTD, bus.irq_ack, bus.NMI} !== {1'b0, 8'h04, 1'b0})
      $display("FAIL t5_ack got=%b/%h/%b want=0/04/0", bus.INTD, bus.irq_ack, bus.NMI);
    else passed++;
    bus.irq_req = '0;
    tick();
    total++; if ({bus.NMI, bus.busy} !== 2'b01)
      $display("FAIL t5_gap got=%b%b want=01", bus.NMI, bus.busy);
    else passed++;
    tick();
    tick();
    total++; if ({bus.NMI, bus.INT} !== 2'b10)
      $display("FAIL t5_nmi got=%b%b want=10", bus.NMI, bus.INT);
    else passed++;
    bus.INA = 1'b1;
    tick();
    bus.INA = 1'b0;
    tick();
    tick();
    total++; if ({bus.NMI, bus.busy} !== 2'b00)
      $display("FAIL t5_merged got=%b%b want=00", bus.NMI, bus.busy);
    else passed++;
    bus.nmi_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid;
    logic bad_seen;
    bus.irq_req = 8'h20;
    tick();
    bus.INA = 1'b1;
    tick();
    bus.INA = 1'b0;
    tick();
    rst         = 1'b1;
    bus.nmi_req = 1'b1;
    tick();
    total++; if ({bus.INT, bus.NMI, bus.INTD, bus.busy, bus.irq_ack} !== {4'b0000, 8'h00})
      $display("FAIL t6_abort got=%b%b%b%b%h want=0000_00", bus.INT, bus.NMI, bus.INTD, bus.busy,
               bus.irq_ack);
    else passed++;
    rst         = 1'b0;
    bus.irq_req = '0;
    bus.INA     = 1'b1;
    bad_seen    = 1'b0;
    repeat (6) begin
      tick();
      if (bus.irq_ack !== 8'h00 || bus.NMI !== 1'b0 || bus.busy !== 1'b0) bad_seen = 1'b1;
    end
    total++; if (bad_seen !== 1'b0) $display("FAIL t6_quiet got=%b want=0", bad_seen);
    else passed++;
    bus.INA     = 1'b0;
    bus.nmi_req = 1'b0;
    tick();
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_basic();
    test_mask();
    test_nmi_priority();
    test_timeout();
    test_nmi_during_shift();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
